pipe_ctrl: RTL

//  Central pipeline sequencer for the 5-stage core. Merges stall requests from
//  ID and EX and exception notifications from MEM. Drives the per-stage stall

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_stall_wdog.sv | 55 +++++
 rtl/pipe_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencer.
//   - stall bus width and the two stall masks (EX hold, ID hold)
//   - MEM exception cause codes
//   - sequencer FSM state encoding
//   - redirect_pc(): flush target decode from the exception cause
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_t;

  // bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_ID   = 6'b000111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_SQUASH = 1'b1
  } state_e;

  // Interrupts go to the interrupt vector, eret returns to EPC, every other
  // nonzero cause (sys/inv/ov/trap and unknown codes) goes to the exception
  // vector.
  function automatic logic [31:0] redirect_pc(
    input logic [31:0] exc,
    input logic [31:0] epc,
    input logic [31:0] exc_vec,
    input logic [31:0] int_vec
  );
    logic [31:0] pc;
    case (exc)
      EXC_INT:  pc = int_vec;
      EXC_ERET: pc = epc;
      default:  pc = exc_vec;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// pipe_ctrl_stall_wdog: stall-duration bookkeeping.
//   clk, rst        core clock, synchronous active-high reset
//   stall_act       some pipeline stage is held this cycle
//   flush           pipeline flush this cycle (restarts the watchdog)
//   stall_timeout   sticky, set once WDOG_LIMIT consecutive stall cycles seen
//   stall_cycles    saturating count of all stalled cycles
module pipe_ctrl_stall_wdog #(
  parameter int WDOG_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_act,
  input  logic             flush,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wdog_d    = wdog_q;
    cnt_d     = cnt_q;
    if (flush || !stall_act)
      wdog_d = '0;
    else if (wdog_q < WD_MAX)
      wdog_d = wdog_q + 1'b1;
    // look at the next value so the flag rises on the edge that completes
    // the WDOG_LIMIT-th stalled cycle
    timeout_d = timeout_q | (wdog_d == WD_MAX);
    if (stall_act && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stall_timeout = timeout_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
//   clk, rst        core clock, synchronous active-high reset (top priority)
//   stallreq_id     ID hold request (load-use)
//   stallreq_ex     EX hold request (multi-cycle mul/div)
//   excepttype      MEM exception cause, 0 = none
//   cp0_epc         return target for eret
//   stall[5:0]      per-stage hold vector, combinational
//   flush           single-cycle clear of all pipeline regs, combinational
//   new_pc          redirect target, valid with flush, else zero
//   stall_timeout   sticky watchdog flag
//   stall_cycles    saturating stalled-cycle perf counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter int          WDOG_LIMIT = 16,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = ZERO_WORD;
    if (rst) begin
      state_d = S_RUN;
    end else if (excepttype != ZERO_WORD) begin
      // exceptions win in both states; a second one while squashing
      // simply re-flushes and keeps us squashing
      flush   = 1'b1;
      new_pc  = redirect_pc(excepttype, cp0_epc, EXC_VECTOR, INT_VECTOR);
      state_d = S_SQUASH;
    end else if (state_q == S_SQUASH) begin
      // hold requests this cycle come from instructions just squashed
      state_d = S_RUN;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  pipe_ctrl_stall_wdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk           (clk),
    .rst           (rst),
    .stall_act     (|stall),
    .flush         (flush),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

endmodule
